// File: rtl/pressure_alarm_controller.sv
// Debounced, operator-acknowledged pressure alarm with peak tracking.
// Optional occurrence counter built only when PRESSURE_ALARM_COUNT_EN is defined.
module pressure_alarm_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CLEAR_CYCLES    = 8,
    parameter int unsigned CNT_WIDTH       = 8
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 sampleValid,
    input  logic                 presureAbnormality,
    input  logic [5:0]           pressureData,
    input  logic                 alarmAck,
    output logic                 alarm,
    output logic                 armed,
    output logic [5:0]           peakPressure,
    output logic [CNT_WIDTH-1:0] alarmCount
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONFIRM = 2'd1,
        S_ALARM   = 2'd2,
        S_RECOVER = 2'd3
    } state_e;

    localparam logic [3:0] DEB_TGT = 4'(DEBOUNCE_CYCLES);
    localparam logic [7:0] CLR_TGT = 8'(CLEAR_CYCLES);

    state_e     state_q, state_d;
    logic [3:0] deb_cnt_q, deb_cnt_d;
    logic [7:0] clr_cnt_q, clr_cnt_d;
    logic [5:0] peak_q, peak_d;
    logic       alarm_q, alarm_d;
    logic       armed_q, armed_d;
    logic       enter_alarm;

    logic       abn_s;
    logic       nrm_s;
    logic [5:0] peak_max;
    logic [3:0] deb_inc;
    logic [7:0] clr_inc;

    assign abn_s    = sampleValid & presureAbnormality;
    assign nrm_s    = sampleValid & ~presureAbnormality;
    assign peak_max = (pressureData > peak_q) ? pressureData : peak_q;
    assign deb_inc  = deb_cnt_q + 4'd1;
    assign clr_inc  = clr_cnt_q + 8'd1;

    // State, counters, peak and registered outputs
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= S_IDLE;
            deb_cnt_q <= '0;
            clr_cnt_q <= '0;
            peak_q    <= '0;
            alarm_q   <= 1'b0;
            armed_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
            clr_cnt_q <= clr_cnt_d;
            peak_q    <= peak_d;
            alarm_q   <= alarm_d;
            armed_q   <= armed_d;
        end
    end

    // Next state: sample-driven transitions, ack wins in ALARM
    always_comb begin
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        clr_cnt_d   = clr_cnt_q;
        peak_d      = peak_q;
        enter_alarm = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (abn_s) begin
                    peak_d = pressureData;
                    if (DEB_TGT == 4'd1) begin
                        state_d     = S_ALARM;
                        deb_cnt_d   = '0;
                        enter_alarm = 1'b1;
                    end else begin
                        state_d   = S_CONFIRM;
                        deb_cnt_d = 4'd1;
                    end
                end
            end
            S_CONFIRM: begin
                if (abn_s) begin
                    peak_d = peak_max;
                    if (deb_inc == DEB_TGT) begin
                        state_d     = S_ALARM;
                        deb_cnt_d   = '0;
                        enter_alarm = 1'b1;
                    end else begin
                        deb_cnt_d = deb_inc;
                    end
                end else if (nrm_s) begin
                    state_d   = S_IDLE;
                    deb_cnt_d = '0;
                end
            end
            S_ALARM: begin
                if (abn_s) begin
                    peak_d = peak_max;
                end
                if (alarmAck) begin
                    state_d   = S_RECOVER;
                    clr_cnt_d = '0;
                end
            end
            S_RECOVER: begin
                if (abn_s) begin
                    clr_cnt_d = '0;
                    peak_d    = peak_max;
                end else if (nrm_s) begin
                    if (clr_inc == CLR_TGT) begin
                        state_d   = S_IDLE;
                        clr_cnt_d = '0;
                    end else begin
                        clr_cnt_d = clr_inc;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                deb_cnt_d = '0;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Output decode from the next state so outputs come straight from flops
    always_comb begin
        alarm_d = 1'b0;
        armed_d = 1'b0;
        unique case (state_d)
            S_IDLE:    armed_d = 1'b1;
            S_ALARM:   alarm_d = 1'b1;
            default: begin
                alarm_d = 1'b0;
                armed_d = 1'b0;
            end
        endcase
    end

    assign alarm        = alarm_q;
    assign armed        = armed_q;
    assign peakPressure = peak_q;

`ifdef PRESSURE_ALARM_COUNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Saturating count of entries into ALARM
    always_comb begin
        cnt_d = cnt_q;
        if (enter_alarm && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    // Occurrence counter register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign alarmCount = cnt_q;
`else
    logic unused_enter_alarm;

    assign unused_enter_alarm = enter_alarm;
    assign alarmCount         = '0;
`endif

endmodule
